evo_sweep_harness: RTL and testbench

Parametrised successor to the switch-driven evolved-circuit test top. It drives a shared stimulus bus into N circuits-under-test (CUTs) and selects one CUT output by index. In manual mode the stimulus follows the switches. In sweep mode it auto-steps every input vector, waits a settle time per vector for sequential CUTs, and accumulates a ones-count and a 16-bit MISR signature of the selected output. It sits between board I/O (switches, keys, LEDs, BCD/7-seg display path) and the CUT bank.

---
 rtl/evo_sweep_harness_if.sv | 32 +++
 rtl/evo_sweep_harness.sv | 157 +++++++++++++++
 tb/tb_evo_sweep_harness.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/evo_sweep_harness_if.sv
// Bundle of the board-side and CUT-side signals of the sweep harness.
//   master : board/testbench side, drives mode/start/sel/manual_in/cut_outs.
//   slave  : harness side, drives stim/sel_out/busy/done/results/sel_active.
// Parameters must match those of the harness instance that uses this bundle.
interface evo_sweep_harness_if #(
    parameter int N_CIRCUITS = 32,
    parameter int SEL_W      = 5,
    parameter int IN_W       = 5
);
    logic                  mode;
    logic                  start;
    logic [SEL_W-1:0]      sel;
    logic [IN_W-1:0]       manual_in;
    logic [N_CIRCUITS-1:0] cut_outs;
    logic [IN_W-1:0]       stim;
    logic                  sel_out;
    logic                  busy;
    logic                  done;
    logic [IN_W:0]         ones_count;
    logic [15:0]           signature;
    logic [SEL_W-1:0]      sel_active;

    modport master (
        output mode, start, sel, manual_in, cut_outs,
        input  stim, sel_out, busy, done, ones_count, signature, sel_active
    );

    modport slave (
        input  mode, start, sel, manual_in, cut_outs,
        output stim, sel_out, busy, done, ones_count, signature, sel_active
    );
endinterface

// File: rtl/evo_sweep_harness.sv
// Stimulus/observation harness for a bank of evolved circuits-under-test.
// Manual mode: stimulus follows manual_in, the selected CUT output is shown.
// Sweep mode: every input vector 0..2^IN_W-1 is applied in turn, held for
// SETTLE_CYCLES cycles, then the selected CUT output is sampled into a
// ones-count and a 16-bit MISR signature.
// Ports:
//   CLOCK_50 : single clock, all state on its rising edge
//   RST_N    : asynchronous active-low reset
//   bus      : slave side of evo_sweep_harness_if (mode/start/sel/manual_in/
//              cut_outs in; stim/sel_out/busy/done/ones_count/signature/
//              sel_active out)
module evo_sweep_harness #(
    parameter int N_CIRCUITS    = 32,
    parameter int SEL_W         = 5,
    parameter int IN_W          = 5,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 RST_N,
    evo_sweep_harness_if.slave   bus
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [IN_W-1:0]   vec_reg, vec_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IN_W-1:0]   stim_reg, stim_next;
    logic              sel_out_reg, sel_out_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [IN_W:0]     ones_reg, ones_next;
    logic [15:0]       sig_reg, sig_next;
    logic [SEL_W-1:0]  sel_active_reg, sel_active_next;
    logic              start_q_reg;

    // Pad the CUT outputs to the full index range so out-of-range selects
    // read a constant 0 instead of an undefined bit.
    logic [2**SEL_W-1:0] cut_padded;
    genvar gi;
    generate
        for (gi = 0; gi < 2**SEL_W; gi++) begin : g_pad
            if (gi < N_CIRCUITS) begin : g_in
                assign cut_padded[gi] = bus.cut_outs[gi];
            end else begin : g_out
                assign cut_padded[gi] = 1'b0;
            end
        end
    endgenerate

    logic sel_bit;
    logic start_edge;
    logic misr_fb;

    assign sel_bit    = cut_padded[sel_active_reg];
    assign start_edge = bus.start & ~start_q_reg;
    assign misr_fb    = sig_reg[15] ^ sel_bit;

    always_comb begin
        state_next      = state_reg;
        vec_next        = vec_reg;
        cnt_next        = cnt_reg;
        stim_next       = stim_reg;
        sel_out_next    = sel_out_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        ones_next       = ones_reg;
        sig_next        = sig_reg;
        sel_active_next = sel_active_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.mode && start_edge) begin
                    // Select is latched here and frozen for the whole sweep.
                    state_next      = SETTLE;
                    sel_active_next = bus.sel;
                    vec_next        = '0;
                    stim_next       = '0;
                    ones_next       = '0;
                    sig_next        = MISR_SEED;
                    done_next       = 1'b0;
                    busy_next       = 1'b1;
                    cnt_next        = CNT_RELOAD;
                end else if (!bus.mode) begin
                    // Manual tracking; sel_out uses the previous sel_active,
                    // so it trails sel by two cycles. Results are untouched.
                    stim_next       = bus.manual_in;
                    sel_active_next = bus.sel;
                    sel_out_next    = sel_bit;
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            SAMPLE: begin
                sel_out_next = sel_bit;
                ones_next    = ones_reg + {{IN_W{1'b0}}, sel_bit};
                sig_next     = {sig_reg[14:0], 1'b0} ^ (misr_fb ? MISR_POLY : 16'h0000);
                if (vec_reg == {IN_W{1'b1}}) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    vec_next   = vec_reg + IN_W'(1);
                    stim_next  = vec_reg + IN_W'(1);
                    cnt_next   = CNT_RELOAD;
                    state_next = SETTLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= IDLE;
            vec_reg        <= '0;
            cnt_reg        <= '0;
            stim_reg       <= '0;
            sel_out_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            ones_reg       <= '0;
            sig_reg        <= MISR_SEED;
            sel_active_reg <= '0;
            start_q_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vec_reg        <= vec_next;
            cnt_reg        <= cnt_next;
            stim_reg       <= stim_next;
            sel_out_reg    <= sel_out_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            ones_reg       <= ones_next;
            sig_reg        <= sig_next;
            sel_active_reg <= sel_active_next;
            start_q_reg    <= bus.start;
        end
    end

    assign bus.stim       = stim_reg;
    assign bus.sel_out    = sel_out_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.ones_count = ones_reg;
    assign bus.signature  = sig_reg;
    assign bus.sel_active = sel_active_reg;
endmodule

// File: tb/tb_evo_sweep_harness.sv
// Directed bench: instance A uses the default parameters (manual-mode check),
// instance B uses N_CIRCUITS=20, IN_W=4, SETTLE_CYCLES=3 with every CUT
// computing stim[0] (sweeps, start handling, latching, async reset).
module tb_evo_sweep_harness;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    evo_sweep_harness_if #(.N_CIRCUITS(32), .SEL_W(5), .IN_W(5)) bus_a ();
    evo_sweep_harness_if #(.N_CIRCUITS(20), .SEL_W(5), .IN_W(4)) bus_b ();

    evo_sweep_harness #(.N_CIRCUITS(32), .SEL_W(5), .IN_W(5), .SETTLE_CYCLES(4)) dut_a (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .bus      (bus_a.slave)
    );

    evo_sweep_harness #(.N_CIRCUITS(20), .SEL_W(5), .IN_W(4), .SETTLE_CYCLES(3)) dut_b (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .bus      (bus_b.slave)
    );

    assign bus_b.cut_outs = {20{bus_b.stim[0]}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] misr_model(input int nvec, input bit use_stim0);
        logic [15:0] s;
        logic        b;
        logic        fb;
        s = 16'hFFFF;
        for (int k = 0; k < nvec; k++) begin
            b  = use_stim0 ? k[0] : 1'b0;
            fb = s[15] ^ b;
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    initial begin
        int j;
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        bus_a.mode = 1'b0; bus_a.start = 1'b0; bus_a.sel = '0;
        bus_a.manual_in = '0; bus_a.cut_outs = '0;
        bus_b.mode = 1'b0; bus_b.start = 1'b0; bus_b.sel = '0;
        bus_b.manual_in = '0;
        #2 rst_n = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_stim",  32'(bus_b.stim), 0);
        chk("rst_busy",  32'(bus_b.busy), 0);
        chk("rst_done",  32'(bus_b.done), 0);
        chk("rst_ones",  32'(bus_b.ones_count), 0);
        chk("rst_sig",   32'(bus_b.signature), 32'hFFFF);
        chk("rst_sela",  32'(bus_b.sel_active), 0);
        chk("rst_selo",  32'(bus_a.sel_out), 0);
        rst_n = 1'b1;
        step();

        // Manual mode on instance A
        bus_a.manual_in = 5'h15;
        bus_a.sel       = 5'd3;
        bus_a.cut_outs  = 32'h0000_0008;
        step();
        chk("man_stim_1cyc", 32'(bus_a.stim), 32'h15);
        chk("man_selo_1cyc", 32'(bus_a.sel_out), 0);
        step();
        chk("man_selo_2cyc", 32'(bus_a.sel_out), 1);
        chk("man_done", 32'(bus_a.done), 0);
        chk("man_busy", 32'(bus_a.busy), 0);

        // Sweep 1: sel=3, start held high, mid-sweep sel/mode changes
        bus_b.mode  = 1'b1;
        bus_b.sel   = 5'd3;
        bus_b.start = 1'b1;
        step();
        chk("sw1_busy_start", 32'(bus_b.busy), 1);
        j = 0;
        while (bus_b.busy && j < 200) begin
            if (j % 4 == 0) chk($sformatf("sw1_stim_v%0d", j / 4), 32'(bus_b.stim), 32'(j / 4));
            if (j == 10) begin
                bus_b.sel  = 5'd31;
                bus_b.mode = 1'b0;
            end
            if (j == 12) chk("sw1_sela_latched", 32'(bus_b.sel_active), 3);
            j++;
            step();
        end
        chk("sw1_busy_cycles", 32'(j), 64);
        chk("sw1_done", 32'(bus_b.done), 1);
        chk("sw1_ones", 32'(bus_b.ones_count), 8);
        chk("sw1_sig", 32'(bus_b.signature), 32'(misr_model(16, 1'b1)));
        chk("sw1_selo", 32'(bus_b.sel_out), 1);
        // mode=0 now: manual tracking resumes, results held
        bus_b.manual_in = 4'hA;
        step();
        step();
        chk("sw1_man_stim", 32'(bus_b.stim), 32'hA);
        chk("sw1_man_sela", 32'(bus_b.sel_active), 31);
        chk("sw1_man_ones", 32'(bus_b.ones_count), 8);
        chk("sw1_man_done", 32'(bus_b.done), 1);
        chk("sw1_man_busy", 32'(bus_b.busy), 0);

        // Start held high through DONE with mode=1: no new edge, no new sweep
        bus_b.mode = 1'b1;
        repeat (5) step();
        chk("hold_no_restart", 32'(bus_b.busy), 0);
        chk("hold_done", 32'(bus_b.done), 1);

        // Sweep 2: out-of-range select, restart from DONE, edge while busy
        bus_b.start = 1'b0;
        step();
        bus_b.sel   = 5'd31;
        bus_b.start = 1'b1;
        step();
        chk("sw2_busy", 32'(bus_b.busy), 1);
        chk("sw2_done_clr", 32'(bus_b.done), 0);
        chk("sw2_ones_clr", 32'(bus_b.ones_count), 0);
        chk("sw2_sig_clr", 32'(bus_b.signature), 32'hFFFF);
        chk("sw2_stim_clr", 32'(bus_b.stim), 0);
        j = 0;
        while (bus_b.busy && j < 200) begin
            if (j == 5)  bus_b.start = 1'b0;
            if (j == 20) bus_b.start = 1'b1;
            j++;
            step();
        end
        chk("sw2_busy_cycles", 32'(j), 64);
        chk("sw2_done", 32'(bus_b.done), 1);
        chk("sw2_ones", 32'(bus_b.ones_count), 0);
        chk("sw2_sig", 32'(bus_b.signature), 32'(misr_model(16, 1'b0)));

        // Sweep 3: asynchronous reset mid-sweep
        bus_b.start = 1'b0;
        bus_b.sel   = 5'd3;
        step();
        bus_b.start = 1'b1;
        step();
        repeat (20) step();
        chk("sw3_busy_pre", 32'(bus_b.busy), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus_b.busy), 0);
        chk("arst_sig",  32'(bus_b.signature), 32'hFFFF);
        chk("arst_ones", 32'(bus_b.ones_count), 0);
        chk("arst_stim", 32'(bus_b.stim), 0);
        chk("arst_done", 32'(bus_b.done), 0);
        chk("arst_sela", 32'(bus_b.sel_active), 0);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
